hazard_scoreboard: RTL

Parametrised hazard detection unit for the 5-stage MIPS pipeline, sitting between the ID stage and the ID/EX register. It tracks pending register writes with per-register countdown counters, covering multi-cycle load, ALU and mul/div latencies. It detects RAW, WAW and mul/div structural hazards and drives PC/IF-ID hold, ID/EX bubble insertion and branch flush. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_pend_cnt.sv | 27 ++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - instruction class / stall cause encodings and latency helpers for the hazard scoreboard
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MD   = 2'd2,
        CLS_NONE = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_RAW    = 2'd1,
        CAUSE_WAW    = 2'd2,
        CAUSE_STRUCT = 2'd3
    } cause_e;

    // Cycles a dependent must wait behind an instruction of the given class.
    function automatic int lat(input logic [1:0] cls, input int alu_lat,
                               input int load_lat, input int md_lat);
        case (cls)
            CLS_ALU:  return alu_lat;
            CLS_LOAD: return load_lat;
            CLS_MD:   return md_lat;
            default:  return 0;
        endcase
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage instruction fields in, pipeline hold/bubble/flush controls out
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_wr_en;
    logic [1:0]            id_class;
    logic                  ex_branch_taken;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  stall_mux;
    logic                  flush_if_id;
    logic [1:0]            stall_cause;
    logic [PERF_W-1:0]     stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_wr_en, id_class, ex_branch_taken,
        input  pc_write, if_id_write, stall_mux, flush_if_id,
               stall_cause, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_wr_en, id_class, ex_branch_taken,
        output pc_write, if_id_write, stall_mux, flush_if_id,
               stall_cause, stall_cycles
    );

endinterface

// File: rtl/hazard_pend_cnt.sv
// rtl/hazard_pend_cnt.sv - single countdown counter with load override and nonzero flag
module hazard_pend_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero
);

    // A load wins over the decrement so a fresh producer always restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign nonzero = |count;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW/WAW/mul-div hazard detection with per-register countdown scoreboard
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_LAT    = 0,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int PERF_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);

    localparam int CNT_W = cnt_width(ALU_LAT, LOAD_LAT, MD_LAT);

    logic [CNT_W-1:0]    pend_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] pend_nz;
    logic [CNT_W-1:0]    id_lat;
    logic [CNT_W-1:0]    md_cnt;
    logic                md_nz;
    logic                md_load;
    logic                raw_rs;
    logic                raw_rt;
    logic                raw;
    logic                waw;
    logic                struct_haz;
    logic                stall;
    logic                flush;
    logic                issue;
    logic [PERF_W-1:0]   perf_cnt;

    assign id_lat = CNT_W'(lat(bus.id_class, ALU_LAT, LOAD_LAT, MD_LAT));

    // Register 0 is hard-wired to zero, so it never carries a pending write.
    assign pend_cnt[0] = '0;
    assign pend_nz[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        logic ld;
        assign ld = issue && bus.id_wr_en && (bus.id_dst == REG_ADDR_W'(r));

        hazard_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (ld),
            .value   (id_lat),
            .dec     (1'b1),
            .count   (pend_cnt[r]),
            .nonzero (pend_nz[r])
        );
    end

    assign md_load = issue && (bus.id_class == CLS_MD);

    hazard_pend_cnt #(.CNT_W(CNT_W)) u_md_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (md_load),
        .value   (CNT_W'(MD_LAT)),
        .dec     (1'b1),
        .count   (md_cnt),
        .nonzero (md_nz)
    );

    assign raw_rs     = bus.id_uses_rs && (bus.id_rs != '0) && pend_nz[bus.id_rs];
    assign raw_rt     = bus.id_uses_rt && (bus.id_rt != '0) && pend_nz[bus.id_rt];
    assign raw        = bus.id_valid && (raw_rs || raw_rt);
    // A younger writer may overlap an older one only if it cannot finish first.
    assign waw        = bus.id_valid && bus.id_wr_en && (bus.id_dst != '0)
                        && (pend_cnt[bus.id_dst] > id_lat);
    assign struct_haz = bus.id_valid && (bus.id_class == CLS_MD) && md_nz;
    assign stall      = raw || waw || struct_haz;
    assign flush      = bus.ex_branch_taken;
    assign issue      = bus.id_valid && !stall && !flush;

    always_comb begin
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.stall_mux   = 1'b0;
        bus.flush_if_id = 1'b0;
        bus.stall_cause = CAUSE_NONE;
        if (flush) begin
            bus.stall_mux   = 1'b1;
            bus.flush_if_id = 1'b1;
        end else if (stall) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.stall_mux   = 1'b1;
            if (raw)      bus.stall_cause = CAUSE_RAW;
            else if (waw) bus.stall_cause = CAUSE_WAW;
            else          bus.stall_cause = CAUSE_STRUCT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (stall && !flush && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = perf_cnt;

    md_busy_range: assert property (@(posedge clk) disable iff (!rst_n)
                                    md_cnt <= CNT_W'(MD_LAT));

endmodule
